seed_req_sched: RTL and testbench
=================================

# seed_req_sched

Request scheduler and sequencer for the 128-bit SEED core. It arbitrates round-robin between two requesters, each presenting a block, a key and a direction flag. It drives the core's two-beat load protocol (block on the start cycle, key on the next cycle) and waits for the core's done flag. It then returns the result to the granted requester, and on a hang it times out and resets the core. It sits between the system-side requesters and the SEED instance, which it owns exclusively.

## Interface

- TIMEOUT, 4096: cycles allowed in WAIT before abort. Legal range 8..65535.

- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- i_fReq0 / i_fReq1  in  1  request from requester 0 / 1; held high until the matching ack.
- i_Blk0 / i_Blk1  in  128  block (plaintext or ciphertext); stable while the request is high.
- i_Key0 / i_Key1  in  128  key; stable while the request is high.
- i_fDec0 / i_fDec1  in  1  1 = decrypt, 0 = encrypt.
- o_fAck0 / o_fAck1  out  1  one-cycle pulse: request accepted, operands captured.
- o_fDone0 / o_fDone1  out  1  one-cycle pulse: o_Data / o_fErr valid for this requester.
- o_Data  out  128  result; held until the next done pulse.
- o_fErr  out  1  qualifies a done pulse: timeout, o_Data = 0.
- o_fBusy  out  1  high in any state other than IDLE.
- o_Core_Rst  out  1  active-low core reset, registered.
- o_Core_fStart  out  1  core start strobe.
- o_Core_Data  out  128  core input bus.
- o_Core_fDec  out  1  direction to the core.
- i_Core_Data  in  128  core result.
- i_Core_fDone  in  1  core done flag.

## Operation

- States: IDLE, LOAD_BLK, LOAD_KEY, WAIT, RESP, CLR.
- **IDLE**
  - If any request is high: pick the winner, capture its block, key, dec flag and id, assert its ack registered, go to LOAD_BLK.
  - No request: stay in IDLE.
- **Round-robin arbitration**
  - The pointer holds the id of the last winner; reset value is 1, so requester 0 wins first.
  - With both requests high, the id not equal to the pointer wins.
  - With one request high, it wins regardless of the pointer.
  - The pointer updates on every grant.
- **LOAD_BLK:** o_Core_fStart=1, o_Core_Data=captured block. Go to LOAD_KEY.
- **LOAD_KEY:** o_Core_fStart=0, o_Core_Data=captured key. Clear the timeout counter. Go to WAIT.
- **WAIT**
  - o_Core_Data holds the key.
  - On i_Core_fDone=1: capture i_Core_Data into o_Data, set o_fErr=0, go to RESP.
  - Otherwise the counter increments. At TIMEOUT-1: set o_Data=0, set o_fErr=1, go to RESP.
  - If done and the counter reaching TIMEOUT-1 occur in the same cycle, done wins.
- **RESP**
  - Assert o_fDone of the captured id for exactly this cycle.
  - If o_fErr=1, go to CLR; otherwise go to IDLE.
- **CLR:** o_Core_Rst=0 for exactly one cycle, then go to IDLE.
- o_Core_fDec holds the captured dec flag from LOAD_BLK through WAIT.
- i_Core_fDone outside WAIT is ignored.
- Requests are sampled only in IDLE. A request still high during its ack cycle is not double-granted, because the state has already left IDLE. A request still high on return to IDLE is treated as a new request.
- Counter width is 16 bits; it never wraps, since it is bounded by TIMEOUT.

## Timing

- Reset values:
  - State IDLE, pointer 1.
  - All acks and dones 0, o_fErr 0, o_fBusy 0.
  - o_Core_Rst 1, o_Core_fStart 0.
  - o_Data 0, o_Core_Data 0, o_Core_fDec 0.
- Reset asserted mid-operation: everything returns to the reset values immediately. No done pulse is issued for the aborted operation.
- Let cycle 0 be the cycle in which a request is sampled in IDLE.
  - Cycle 1: ack pulse and LOAD_BLK (start strobe).
  - Cycle 2: LOAD_KEY.
  - Cycle 3: first WAIT cycle.
- If the core asserts done in cycle d, then RESP (done pulse, data valid) is cycle d+1 and IDLE is cycle d+2.
- Back-to-back throughput: a new grant can be sampled in cycle d+2.
- Timeout: with no core done, RESP occurs at cycle 3+TIMEOUT, CLR at 4+TIMEOUT and IDLE at 5+TIMEOUT.

## Test plan

- **Encrypt, requester 0.** Key 00010203_04050607_08090A0B_0C0D0E0F, block 0, dec=0 -> o_fAck0 at cycle 1; o_fDone0 with o_Data = C11F22F2_01405050_84483597_E4370F43 and o_fErr=0. o_fDone1 never pulses.
- **Decrypt, requester 1.** Key 28DBC3BC_49FFD87D_CFA509B1_1D422BE7, block 9B9B7BFC_D1813CB9_5D0B3618_F40F5122, dec=1 -> o_fDone1 with o_Data = B41E6BE2_EBA84A14_8E2EED84_593C5EC7.
- **Simultaneous requests, held continuously.** Requester 0 encrypts key 47064808_51E61BE8_5D74BFB3_FD956185, block 83A2F8A2_88641FB9_A4E9A5CC_2F131C7D; requester 1 runs the same as scenario 2 -> grant order 0, 1, 0, 1. Requester 0 results equal EE54D13E_BCAE706D_226BC314_2CD40D4A. Exactly one ack per IDLE visit.
- **Timeout.** Replace the core with a stub that never asserts done, TIMEOUT=16 -> o_fDone0 with o_fErr=1 and o_Data=0 at cycle 19. o_Core_Rst=0 for one cycle at cycle 20, then o_fBusy=0 at cycle 21.
- **Reset mid-WAIT.** Pull Rst low 5 cycles into WAIT -> all outputs at their reset values while Rst is low; no o_fDone. After release, a fresh request from requester 0 completes scenario 1 correctly with requester 0 granted first.
- **Spurious core done.** Assert i_Core_fDone while in IDLE -> no state change, no done pulse.

Source files
------------

// File: rtl/seed_req_sched.sv
// Round-robin request scheduler for a SEED core: arbitrates two requesters, drives the
// two-beat block/key load, waits for done with a timeout, returns the result, resets the core on a hang.
module seed_req_sched #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         i_fReq0,
    input  logic         i_fReq1,
    input  logic [127:0] i_Blk0,
    input  logic [127:0] i_Blk1,
    input  logic [127:0] i_Key0,
    input  logic [127:0] i_Key1,
    input  logic         i_fDec0,
    input  logic         i_fDec1,
    output logic         o_fAck0,
    output logic         o_fAck1,
    output logic         o_fDone0,
    output logic         o_fDone1,
    output logic [127:0] o_Data,
    output logic         o_fErr,
    output logic         o_fBusy,
    output logic         o_Core_Rst,
    output logic         o_Core_fStart,
    output logic [127:0] o_Core_Data,
    output logic         o_Core_fDec,
    input  logic [127:0] i_Core_Data,
    input  logic         i_Core_fDone
);

    typedef enum logic [2:0] {StIdle, StLoadBlk, StLoadKey, StWait, StResp, StClr} state_e;

    localparam logic [15:0] CntMax = 16'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d, id_q, id_d, dec_q, dec_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d, core_rst_q, core_rst_d;
    logic [127:0]  blk_q, blk_d, key_q, key_d, data_q, data_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          win;

    // Pointer holds the last winner; on contention the other requester wins.
    always_comb begin
        win = (i_fReq0 && i_fReq1) ? ~ptr_q : i_fReq1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        dec_d   = dec_q;
        blk_d   = blk_q;
        key_d   = key_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_fReq0 || i_fReq1) begin
                    ptr_d   = win;
                    id_d    = win;
                    blk_d   = win ? i_Blk1 : i_Blk0;
                    key_d   = win ? i_Key1 : i_Key0;
                    dec_d   = win ? i_fDec1 : i_fDec0;
                    ack0_d  = ~win;
                    ack1_d  = win;
                    state_d = StLoadBlk;
                end
            end
            StLoadBlk: state_d = StLoadKey;
            StLoadKey: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Done takes priority over a simultaneous timeout.
                if (i_Core_fDone) begin
                    data_d  = i_Core_Data;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntMax) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: state_d = err_q ? StClr : StIdle;
            StClr: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        core_rst_d = (state_d != StClr);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b1;
            id_q       <= 1'b0;
            dec_q      <= 1'b0;
            blk_q      <= '0;
            key_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            dec_q      <= dec_d;
            blk_q      <= blk_d;
            key_q      <= key_d;
            data_q     <= data_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            core_rst_q <= core_rst_d;
        end
    end

    always_comb begin
        o_Core_Data = '0;
        o_Core_fDec = 1'b0;
        unique case (state_q)
            StLoadBlk: begin
                o_Core_Data = blk_q;
                o_Core_fDec = dec_q;
            end
            StLoadKey, StWait: begin
                o_Core_Data = key_q;
                o_Core_fDec = dec_q;
            end
            default: ;
        endcase
    end

    assign o_fAck0       = ack0_q;
    assign o_fAck1       = ack1_q;
    assign o_fDone0      = (state_q == StResp) && !id_q;
    assign o_fDone1      = (state_q == StResp) && id_q;
    assign o_Data        = data_q;
    assign o_fErr        = err_q;
    assign o_fBusy       = (state_q != StIdle);
    assign o_Core_Rst    = core_rst_q;
    assign o_Core_fStart = (state_q == StLoadBlk);

endmodule

// File: tb/tb_seed_req_sched.sv
// Scoreboard bench for seed_req_sched; a behavioural core stub answers known SEED vectors.
module tb_seed_req_sched;

    localparam logic [127:0] K1 = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    localparam logic [127:0] B1 = 128'h0;
    localparam logic [127:0] R1 = 128'hC11F22F2_01405050_84483597_E4370F43;
    localparam logic [127:0] K2 = 128'h28DBC3BC_49FFD87D_CFA509B1_1D422BE7;
    localparam logic [127:0] B2 = 128'h9B9B7BFC_D1813CB9_5D0B3618_F40F5122;
    localparam logic [127:0] R2 = 128'hB41E6BE2_EBA84A14_8E2EED84_593C5EC7;
    localparam logic [127:0] K3 = 128'h47064808_51E61BE8_5D74BFB3_FD956185;
    localparam logic [127:0] B3 = 128'h83A2F8A2_88641FB9_A4E9A5CC_2F131C7D;
    localparam logic [127:0] R3 = 128'hEE54D13E_BCAE706D_226BC314_2CD40D4A;
    localparam logic [127:0] BadRes = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         i_fReq0 = 1'b0, i_fReq1 = 1'b0;
    logic [127:0] i_Blk0 = '0, i_Blk1 = '0, i_Key0 = '0, i_Key1 = '0;
    logic         i_fDec0 = 1'b0, i_fDec1 = 1'b0;
    logic         o_fAck0, o_fAck1, o_fDone0, o_fDone1, o_fErr, o_fBusy;
    logic [127:0] o_Data, o_Core_Data;
    logic         o_Core_Rst, o_Core_fStart, o_Core_fDec;
    logic [127:0] i_Core_Data;
    logic         i_Core_fDone;

    typedef struct {
        logic         id;
        logic [127:0] data;
        logic         err;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    seed_req_sched #(.TIMEOUT(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .i_fReq0(i_fReq0), .i_fReq1(i_fReq1),
        .i_Blk0(i_Blk0), .i_Blk1(i_Blk1), .i_Key0(i_Key0), .i_Key1(i_Key1),
        .i_fDec0(i_fDec0), .i_fDec1(i_fDec1),
        .o_fAck0(o_fAck0), .o_fAck1(o_fAck1), .o_fDone0(o_fDone0), .o_fDone1(o_fDone1),
        .o_Data(o_Data), .o_fErr(o_fErr), .o_fBusy(o_fBusy),
        .o_Core_Rst(o_Core_Rst), .o_Core_fStart(o_Core_fStart), .o_Core_Data(o_Core_Data),
        .o_Core_fDec(o_Core_fDec), .i_Core_Data(i_Core_Data), .i_Core_fDone(i_Core_fDone)
    );

    // Core stub: latches block on start, key one cycle later, answers after lat cycles.
    logic         hang = 1'b0;
    logic         spur = 1'b0;
    int           lat = 3;
    logic [127:0] s_blk, s_key, s_res;
    logic         s_dec, s_done;
    int           s_ph, s_cnt;

    function automatic logic [127:0] seed_ref(input logic [127:0] b, input logic [127:0] k,
                                              input logic d);
        if (b == B1 && k == K1 && !d) return R1;
        if (b == B2 && k == K2 && d) return R2;
        if (b == B3 && k == K3 && !d) return R3;
        return BadRes;
    endfunction

    always @(posedge Clk or negedge Rst) begin
        if (!Rst || !o_Core_Rst) begin
            s_ph   <= 0;
            s_cnt  <= 0;
            s_done <= 1'b0;
            s_res  <= '0;
            s_blk  <= '0;
            s_key  <= '0;
            s_dec  <= 1'b0;
        end else begin
            s_done <= 1'b0;
            if (o_Core_fStart) begin
                s_blk <= o_Core_Data;
                s_ph  <= 1;
            end else if (s_ph == 1) begin
                s_key <= o_Core_Data;
                s_dec <= o_Core_fDec;
                s_cnt <= lat;
                s_ph  <= 2;
            end else if (s_ph == 2 && !hang) begin
                if (s_cnt == 0) begin
                    s_done <= 1'b1;
                    s_res  <= seed_ref(s_blk, s_key, s_dec);
                    s_ph   <= 0;
                end else begin
                    s_cnt <= s_cnt - 1;
                end
            end
        end
    end

    assign i_Core_fDone = s_done | spur;
    assign i_Core_Data  = s_res;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk1({name, "_ack0"}, o_fAck0, 1'b0);
        chk1({name, "_ack1"}, o_fAck1, 1'b0);
        chk1({name, "_done0"}, o_fDone0, 1'b0);
        chk1({name, "_done1"}, o_fDone1, 1'b0);
        chk1({name, "_err"}, o_fErr, 1'b0);
        chk1({name, "_busy"}, o_fBusy, 1'b0);
        chk1({name, "_core_rst"}, o_Core_Rst, 1'b1);
        chk1({name, "_start"}, o_Core_fStart, 1'b0);
        chk1({name, "_core_dec"}, o_Core_fDec, 1'b0);
        chk128({name, "_data"}, o_Data, '0);
        chk128({name, "_core_data"}, o_Core_Data, '0);
    endtask

    // Monitor: every done pulse pops one expected response.
    always @(negedge Clk) begin
        if (Rst) begin
            if (o_fAck0 && o_fAck1) chk1("ack_onehot", 1'b1, 1'b0);
            if (o_fDone0 || o_fDone1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done0=%b done1=%b want none",
                             o_fDone0, o_fDone1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk1("done_onehot", o_fDone0 & o_fDone1, 1'b0);
                    chk1("done_id", o_fDone1, e.id);
                    chk128("done_data", o_Data, e.data);
                    chk1("done_err", o_fErr, e.err);
                end
            end
        end
    end

    task automatic push_exp(input logic id, input logic [127:0] data, input logic err);
        exp_t e;
        e.id = id;
        e.data = data;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic req_once(input int id, input logic [127:0] blk, input logic [127:0] key,
                            input logic dec);
        int n = 0;
        if (id == 0) begin
            i_Blk0 = blk; i_Key0 = key; i_fDec0 = dec; i_fReq0 = 1'b1;
        end else begin
            i_Blk1 = blk; i_Key1 = key; i_fDec1 = dec; i_fReq1 = 1'b1;
        end
        do begin
            @(negedge Clk);
            n++;
        end while (!(id == 0 ? o_fAck0 : o_fAck1) && n < 400);
        chk1("ack_seen", (id == 0 ? o_fAck0 : o_fAck1), 1'b1);
        if (id == 0) i_fReq0 = 1'b0;
        else i_fReq1 = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        chk1(name, exp_q.size() == 0, 1'b1);
    endtask

    initial begin
        int acks;
        int n;
        @(negedge Clk);
        chk_reset("rst");
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);

        // Encrypt from requester 0, checking ack lands in cycle 1
        push_exp(1'b0, R1, 1'b0);
        i_Blk0 = B1; i_Key0 = K1; i_fDec0 = 1'b0; i_fReq0 = 1'b1;
        @(negedge Clk);
        chk1("s1_ack_cycle1", o_fAck0, 1'b1);
        chk1("s1_start_cycle1", o_Core_fStart, 1'b1);
        chk128("s1_core_blk", o_Core_Data, B1);
        i_fReq0 = 1'b0;
        @(negedge Clk);
        chk128("s1_core_key", o_Core_Data, K1);
        chk1("s1_start_low", o_Core_fStart, 1'b0);
        wait_empty("s1_complete");

        // Decrypt from requester 1
        push_exp(1'b1, R2, 1'b0);
        req_once(1, B2, K2, 1'b1);
        chk1("s2_core_dec", o_Core_fDec, 1'b1);
        wait_empty("s2_complete");

        // Both held: grants alternate 0,1,0,1
        push_exp(1'b0, R3, 1'b0);
        push_exp(1'b1, R2, 1'b0);
        push_exp(1'b0, R3, 1'b0);
        push_exp(1'b1, R2, 1'b0);
        i_Blk0 = B3; i_Key0 = K3; i_fDec0 = 1'b0;
        i_Blk1 = B2; i_Key1 = K2; i_fDec1 = 1'b1;
        i_fReq0 = 1'b1; i_fReq1 = 1'b1;
        acks = 0;
        n = 0;
        while (acks < 4 && n < 400) begin
            @(negedge Clk);
            n++;
            if (o_fAck0 || o_fAck1) acks++;
        end
        i_fReq0 = 1'b0; i_fReq1 = 1'b0;
        chk1("s3_four_acks", acks == 4, 1'b1);
        wait_empty("s3_complete");

        // Done landing on the last counter value beats the timeout
        lat = 14;
        push_exp(1'b0, R1, 1'b0);
        req_once(0, B1, K1, 1'b0);
        wait_empty("edge_complete");
        lat = 3;

        // Timeout with a hung core
        hang = 1'b1;
        push_exp(1'b0, '0, 1'b1);
        i_Blk0 = B1; i_Key0 = K1; i_fDec0 = 1'b0; i_fReq0 = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                chk1("to_ack", o_fAck0, 1'b1);
                i_fReq0 = 1'b0;
            end
            chk1($sformatf("to_done0_c%0d", k), o_fDone0, k == 19);
            chk1($sformatf("to_core_rst_c%0d", k), o_Core_Rst, k != 20);
            chk1($sformatf("to_busy_c%0d", k), o_fBusy, k <= 20);
        end
        hang = 1'b0;
        wait_empty("to_complete");

        // Reset five cycles into WAIT: no done, pointer back to 1
        hang = 1'b1;
        req_once(0, B1, K1, 1'b0);
        repeat (7) @(negedge Clk);
        chk1("mid_busy_before", o_fBusy, 1'b1);
        Rst = 1'b0;
        #1;
        chk_reset("mid_rst_now");
        @(negedge Clk);
        chk_reset("mid_rst_held");
        hang = 1'b0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        chk1("mid_idle_after", o_fBusy, 1'b0);
        push_exp(1'b0, R1, 1'b0);
        push_exp(1'b1, R2, 1'b0);
        fork
            req_once(0, B1, K1, 1'b0);
            req_once(1, B2, K2, 1'b1);
        join
        wait_empty("mid_after_complete");

        // Spurious core done in IDLE
        spur = 1'b1;
        @(negedge Clk);
        spur = 1'b0;
        chk1("spur_busy", o_fBusy, 1'b0);
        @(negedge Clk);
        chk1("spur_busy2", o_fBusy, 1'b0);
        chk1("spur_done0", o_fDone0, 1'b0);
        chk1("spur_done1", o_fDone1, 1'b0);
        repeat (3) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
